// File: rtl/user_op_arbiter.sv
// Two-requester arbiter for the SPI flash controller user port.
// One requester is granted at a time; its command is registered toward the
// controller and its write/read streams are muxed combinationally until the
// controller signals completion with a rising edge of i_user_op_ready.
//
// Handshake semantics: a command transfers on a cycle where valid and ready are
// both high. o_user_op_valid stays high until that cycle. The granted requester
// receives a single-cycle o_reqN_op_ready in the same cycle, and must hold its
// i_reqN_op_valid until it sees that pulse.
module user_op_arbiter #(
  parameter bit P_FIXED_PRIO = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // requester 0
  input  logic [1:0]  i_req0_op_type,
  input  logic [23:0] i_req0_op_addr,
  input  logic [8:0]  i_req0_op_num,
  input  logic        i_req0_op_valid,
  output logic        o_req0_op_ready,
  input  logic [7:0]  i_req0_write_data,
  input  logic        i_req0_write_sop,
  input  logic        i_req0_write_eop,
  input  logic        i_req0_write_valid,
  output logic [7:0]  o_req0_read_data,
  output logic        o_req0_read_sop,
  output logic        o_req0_read_eop,
  output logic        o_req0_read_valid,
  // requester 1
  input  logic [1:0]  i_req1_op_type,
  input  logic [23:0] i_req1_op_addr,
  input  logic [8:0]  i_req1_op_num,
  input  logic        i_req1_op_valid,
  output logic        o_req1_op_ready,
  input  logic [7:0]  i_req1_write_data,
  input  logic        i_req1_write_sop,
  input  logic        i_req1_write_eop,
  input  logic        i_req1_write_valid,
  output logic [7:0]  o_req1_read_data,
  output logic        o_req1_read_sop,
  output logic        o_req1_read_eop,
  output logic        o_req1_read_valid,
  // controller side
  output logic [1:0]  o_user_op_type,
  output logic [23:0] o_user_op_addr,
  output logic [8:0]  o_user_op_num,
  output logic        o_user_op_valid,
  input  logic        i_user_op_ready,
  output logic [7:0]  o_user_write_data,
  output logic        o_user_write_sop,
  output logic        o_user_write_eop,
  output logic        o_user_write_valid,
  input  logic [7:0]  i_user_read_data,
  input  logic        i_user_read_sop,
  input  logic        i_user_read_eop,
  input  logic        i_user_read_valid,
  output logic [1:0]  o_grant,
  // FSM state for observation: 0 = IDLE, 1 = CMD, 2 = BUSY
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic r_last;      // requester granted most recently
  logic r_win;       // requester currently granted
  logic r_low_seen;  // controller ready has dropped since the accept
  logic w_start;
  logic w_pick;
  logic w_active;
  logic w_done;
  logic w_granted;

  // Arbitration, handshake and completion decode
  always_comb begin
    w_start  = (i_req0_op_valid | i_req1_op_valid) & i_user_op_ready;
    if (i_req0_op_valid && i_req1_op_valid) begin
      w_pick = P_FIXED_PRIO ? 1'b0 : ~r_last;
    end else begin
      w_pick = ~i_req0_op_valid;
    end
    w_active = o_user_op_valid & i_user_op_ready;
    // Only a ready that rises after having been low marks completion
    w_done   = (r_state == ST_BUSY) & i_user_op_ready & r_low_seen;
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start)  w_next = ST_CMD;
      ST_CMD:  if (w_active) w_next = ST_BUSY;
      ST_BUSY: if (w_done)   w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Registered command, grant and arbitration history
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_user_op_type  <= 2'd0;
      o_user_op_addr  <= 24'd0;
      o_user_op_num   <= 9'd0;
      o_user_op_valid <= 1'b0;
      o_grant         <= 2'b00;
      r_win           <= 1'b0;
      r_last          <= 1'b1;
      r_low_seen      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            o_user_op_type  <= w_pick ? i_req1_op_type : i_req0_op_type;
            o_user_op_addr  <= w_pick ? i_req1_op_addr : i_req0_op_addr;
            o_user_op_num   <= w_pick ? i_req1_op_num  : i_req0_op_num;
            o_user_op_valid <= 1'b1;
            o_grant         <= w_pick ? 2'b10 : 2'b01;
            r_win           <= w_pick;
          end
        end
        ST_CMD: begin
          if (w_active) begin
            o_user_op_valid <= 1'b0;
            r_low_seen      <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (!i_user_op_ready) begin
            r_low_seen <= 1'b1;
          end
          if (w_done) begin
            r_last  <= r_win;
            o_grant <= 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: accept pulse and stream routing to/from the granted requester
  always_comb begin
    w_granted          = (r_state == ST_CMD) || (r_state == ST_BUSY);
    o_dbg_state        = r_state;
    o_req0_op_ready    = (r_state == ST_CMD) & w_active & ~r_win;
    o_req1_op_ready    = (r_state == ST_CMD) & w_active &  r_win;

    o_user_write_data  = 8'd0;
    o_user_write_sop   = 1'b0;
    o_user_write_eop   = 1'b0;
    o_user_write_valid = 1'b0;
    o_req0_read_data   = 8'd0;
    o_req0_read_sop    = 1'b0;
    o_req0_read_eop    = 1'b0;
    o_req0_read_valid  = 1'b0;
    o_req1_read_data   = 8'd0;
    o_req1_read_sop    = 1'b0;
    o_req1_read_eop    = 1'b0;
    o_req1_read_valid  = 1'b0;

    if (w_granted) begin
      if (r_win) begin
        o_user_write_data  = i_req1_write_data;
        o_user_write_sop   = i_req1_write_sop;
        o_user_write_eop   = i_req1_write_eop;
        o_user_write_valid = i_req1_write_valid;
        o_req1_read_data   = i_user_read_data;
        o_req1_read_sop    = i_user_read_sop;
        o_req1_read_eop    = i_user_read_eop;
        o_req1_read_valid  = i_user_read_valid;
      end else begin
        o_user_write_data  = i_req0_write_data;
        o_user_write_sop   = i_req0_write_sop;
        o_user_write_eop   = i_req0_write_eop;
        o_user_write_valid = i_req0_write_valid;
        o_req0_read_data   = i_user_read_data;
        o_req0_read_sop    = i_user_read_sop;
        o_req0_read_eop    = i_user_read_eop;
        o_req0_read_valid  = i_user_read_valid;
      end
    end
  end

endmodule

// File: tb/tb_user_op_arbiter.sv
// Directed bench for user_op_arbiter. Two instances share every input: one
// round-robin, one fixed-priority, so both arbitration policies are observed
// against the same controller behaviour.
module tb_user_op_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [1:0]  t0 = 2'd0, t1 = 2'd0;
  logic [23:0] a0 = 24'd0, a1 = 24'd0;
  logic [8:0]  n0 = 9'd0, n1 = 9'd0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [7:0]  wd0 = 8'd0, wd1 = 8'd0;
  logic        ws0 = 1'b0, we0 = 1'b0, wv0 = 1'b0;
  logic        ws1 = 1'b0, we1 = 1'b0, wv1 = 1'b0;
  logic        ready = 1'b1;
  logic [7:0]  rd = 8'd0;
  logic        rs = 1'b0, re = 1'b0, rv = 1'b0;

  // round-robin instance outputs
  logic        opr0, opr1;
  logic [7:0]  rd0, rd1;
  logic        rs0, re0, rv0, rs1, re1, rv1;
  logic [1:0]  u_type;
  logic [23:0] u_addr;
  logic [8:0]  u_num;
  logic        u_valid;
  logic [7:0]  uw_data;
  logic        uw_sop, uw_eop, uw_valid;
  logic [1:0]  grant, state;

  // fixed-priority instance outputs
  logic        f_opr0, f_opr1;
  logic [7:0]  f_rd0, f_rd1;
  logic        f_rs0, f_re0, f_rv0, f_rs1, f_re1, f_rv1;
  logic [1:0]  f_type;
  logic [23:0] f_addr;
  logic [8:0]  f_num;
  logic        f_valid;
  logic [7:0]  f_uw_data;
  logic        f_uw_sop, f_uw_eop, f_uw_valid;
  logic [1:0]  f_grant, f_state;

  int errors = 0;
  int checks = 0;

  user_op_arbiter #(.P_FIXED_PRIO(1'b0)) dut_rr (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_op_type(t0), .i_req0_op_addr(a0), .i_req0_op_num(n0),
    .i_req0_op_valid(v0), .o_req0_op_ready(opr0),
    .i_req0_write_data(wd0), .i_req0_write_sop(ws0), .i_req0_write_eop(we0),
    .i_req0_write_valid(wv0),
    .o_req0_read_data(rd0), .o_req0_read_sop(rs0), .o_req0_read_eop(re0),
    .o_req0_read_valid(rv0),
    .i_req1_op_type(t1), .i_req1_op_addr(a1), .i_req1_op_num(n1),
    .i_req1_op_valid(v1), .o_req1_op_ready(opr1),
    .i_req1_write_data(wd1), .i_req1_write_sop(ws1), .i_req1_write_eop(we1),
    .i_req1_write_valid(wv1),
    .o_req1_read_data(rd1), .o_req1_read_sop(rs1), .o_req1_read_eop(re1),
    .o_req1_read_valid(rv1),
    .o_user_op_type(u_type), .o_user_op_addr(u_addr), .o_user_op_num(u_num),
    .o_user_op_valid(u_valid), .i_user_op_ready(ready),
    .o_user_write_data(uw_data), .o_user_write_sop(uw_sop),
    .o_user_write_eop(uw_eop), .o_user_write_valid(uw_valid),
    .i_user_read_data(rd), .i_user_read_sop(rs), .i_user_read_eop(re),
    .i_user_read_valid(rv),
    .o_grant(grant), .o_dbg_state(state)
  );

  user_op_arbiter #(.P_FIXED_PRIO(1'b1)) dut_fp (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_op_type(t0), .i_req0_op_addr(a0), .i_req0_op_num(n0),
    .i_req0_op_valid(v0), .o_req0_op_ready(f_opr0),
    .i_req0_write_data(wd0), .i_req0_write_sop(ws0), .i_req0_write_eop(we0),
    .i_req0_write_valid(wv0),
    .o_req0_read_data(f_rd0), .o_req0_read_sop(f_rs0), .o_req0_read_eop(f_re0),
    .o_req0_read_valid(f_rv0),
    .i_req1_op_type(t1), .i_req1_op_addr(a1), .i_req1_op_num(n1),
    .i_req1_op_valid(v1), .o_req1_op_ready(f_opr1),
    .i_req1_write_data(wd1), .i_req1_write_sop(ws1), .i_req1_write_eop(we1),
    .i_req1_write_valid(wv1),
    .o_req1_read_data(f_rd1), .o_req1_read_sop(f_rs1), .o_req1_read_eop(f_re1),
    .o_req1_read_valid(f_rv1),
    .o_user_op_type(f_type), .o_user_op_addr(f_addr), .o_user_op_num(f_num),
    .o_user_op_valid(f_valid), .i_user_op_ready(ready),
    .o_user_write_data(f_uw_data), .o_user_write_sop(f_uw_sop),
    .o_user_write_eop(f_uw_eop), .o_user_write_valid(f_uw_valid),
    .i_user_read_data(rd), .i_user_read_sop(rs), .i_user_read_eop(re),
    .i_user_read_valid(rv),
    .o_grant(f_grant), .o_dbg_state(f_state)
  );

  // clock
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // command the controller should see for a grant to requester idx
  function automatic logic [34:0] exp_cmd(input logic idx);
    return idx ? {t1, a1, n1} : {t0, a0, n0};
  endfunction

  // One complete operation starting in IDLE with ready high:
  // accept, busy for busy_n cycles with ready low, then ready rises.
  task automatic do_op(input string tag, input logic [1:0] g_rr, input logic [1:0] g_fp,
                       input int busy_n);
    @(posedge i_clk); #1;
    chk({tag, " grant_rr"}, grant, g_rr);
    chk({tag, " grant_fp"}, f_grant, g_fp);
    chk({tag, " valid_rr"}, u_valid, 1'b1);
    chk({tag, " cmd_rr"}, {u_type, u_addr, u_num}, exp_cmd(g_rr[1]));
    chk({tag, " cmd_fp"}, {f_type, f_addr, f_num}, exp_cmd(g_fp[1]));
    chk({tag, " opready_rr"}, {opr1, opr0}, g_rr);
    chk({tag, " opready_fp"}, {f_opr1, f_opr0}, g_fp);
    @(posedge i_clk); #1;
    ready = 1'b0;
    chk({tag, " busy_valid"}, u_valid, 1'b0);
    chk({tag, " busy_opready"}, {opr1, opr0}, 2'b00);
    chk({tag, " busy_state"}, state, 2'd2);
    repeat (busy_n) @(posedge i_clk);
    #1;
    chk({tag, " busy_grant"}, grant, g_rr);
    ready = 1'b1;
    @(posedge i_clk); #1;
    chk({tag, " done_grant_rr"}, grant, 2'b00);
    chk({tag, " done_grant_fp"}, f_grant, 2'b00);
    chk({tag, " done_state"}, state, 2'd0);
  endtask

  initial begin
    // ---- reset values ----
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst grant", grant, 2'b00);
    chk("rst state", state, 2'd0);
    chk("rst cmd", {u_type, u_addr, u_num, u_valid}, 36'd0);
    chk("rst opready", {opr0, opr1}, 2'b00);
    chk("rst user_write", {uw_data, uw_sop, uw_eop, uw_valid}, 11'd0);
    chk("rst reads", {rd0, rs0, re0, rv0, rd1, rs1, re1, rv1}, 22'd0);
    i_rst = 1'b0;

    // ---- single request: req0 write 0x000100 num 2, busy 20 cycles ----
    t0 = 2'd1; a0 = 24'h000100; n0 = 9'd2; v0 = 1'b1;
    @(posedge i_clk); #1;
    chk("single grant", grant, 2'b01);
    chk("single cmd", {u_type, u_addr, u_num, u_valid}, {2'd1, 24'h000100, 9'd2, 1'b1});
    chk("single opready", {opr1, opr0}, 2'b01);
    @(posedge i_clk); #1;
    v0 = 1'b0;
    ready = 1'b0;
    chk("single opready_once", {opr1, opr0}, 2'b00);
    repeat (19) @(posedge i_clk);
    #1;
    chk("single busy_grant", grant, 2'b01);
    chk("single busy_state", state, 2'd2);
    ready = 1'b1;
    @(posedge i_clk); #1;
    chk("single idle_state", state, 2'd0);
    chk("single idle_grant", grant, 2'b00);

    // ---- completion edge: ready high 3 cycles after accept, low 5, then high ----
    t1 = 2'd2; a1 = 24'h000200; n1 = 9'd4; v1 = 1'b1;
    @(posedge i_clk); #1;
    chk("edge grant", grant, 2'b10);
    @(posedge i_clk); #1;
    v1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
      chk("edge hold_high", {state, grant}, {2'd2, 2'b10});
    end
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk); #1;
      chk("edge hold_low", {state, grant}, {2'd2, 2'b10});
    end
    ready = 1'b1;
    @(posedge i_clk); #1;
    chk("edge done", {state, grant}, {2'd0, 2'b00});

    // ---- stream isolation: req1 read num 4 while req0 drives writes ----
    wd0 = 8'h33; ws0 = 1'b1; we0 = 1'b1; wv0 = 1'b1;
    #1;
    chk("iso idle_write", {uw_data, uw_valid}, 9'd0);
    v1 = 1'b1;
    @(posedge i_clk); #1;
    chk("iso grant", grant, 2'b10);
    @(posedge i_clk); #1;
    v1 = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd = 8'hA0 + 8'(i); rv = 1'b1; rs = (i == 0); re = (i == 3);
      #1;
      chk("iso req1_read", {rd1, rv1, rs1, re1}, {8'hA0 + 8'(i), 1'b1, i == 0, i == 3});
      chk("iso req0_read", {rd0, rv0, rs0, re0}, 11'd0);
      chk("iso user_write", uw_valid, 1'b0);
      @(posedge i_clk); #1;
    end
    rv = 1'b0; rs = 1'b0; re = 1'b0;
    wd1 = 8'h5C; ws1 = 1'b1; we1 = 1'b1; wv1 = 1'b1;
    #1;
    chk("iso req1_write", {uw_data, uw_sop, uw_eop, uw_valid}, {8'h5C, 3'b111});
    wd1 = 8'h00; ws1 = 1'b0; we1 = 1'b0; wv1 = 1'b0;
    ready = 1'b1;
    @(posedge i_clk); #1;
    chk("iso done_state", state, 2'd0);
    rd = 8'h77; rv = 1'b1;
    #1;
    chk("iso idle_reads", {rv0, rv1, rd0, rd1}, 18'd0);
    rd = 8'h00; rv = 1'b0;
    wd0 = 8'h00; ws0 = 1'b0; we0 = 1'b0; wv0 = 1'b0;

    // ---- simultaneous requests from reset: rr alternates, fp always req0 ----
    i_rst = 1'b1;
    t0 = 2'd2; a0 = 24'hAAAAAA; n0 = 9'd5;
    t1 = 2'd3; a1 = 24'h123456; n1 = 9'h1FF;
    v0 = 1'b1; v1 = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    do_op("sim op1", 2'b01, 2'b01, 4);
    do_op("sim op2", 2'b10, 2'b01, 4);
    do_op("sim op3", 2'b01, 2'b01, 4);
    do_op("sim op4", 2'b10, 2'b01, 4);
    v0 = 1'b0;
    do_op("sim req1_only", 2'b10, 2'b10, 3);
    v0 = 1'b1; v1 = 1'b0;
    do_op("sim req0_only", 2'b01, 2'b01, 3);

    // ---- reset in BUSY: rr would next pick req1, reset restores req0 first ----
    v1 = 1'b1;
    @(posedge i_clk); #1;
    chk("mid grant_rr", grant, 2'b10);
    chk("mid grant_fp", f_grant, 2'b01);
    @(posedge i_clk); #1;
    ready = 1'b0;
    wv1 = 1'b1; rv = 1'b1;
    @(posedge i_clk); #1;
    chk("mid busy_state", state, 2'd2);
    i_rst = 1'b1;
    #1;
    chk("mid rst cmd", {u_type, u_addr, u_num, u_valid}, 36'd0);
    chk("mid rst grant", {grant, f_grant, state}, 6'd0);
    chk("mid rst opready", {opr0, opr1}, 2'b00);
    chk("mid rst streams", {uw_valid, rv0, rv1, rd0, rd1}, 19'd0);
    wv1 = 1'b0; rv = 1'b0;
    ready = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    chk("mid first_grant_rr", grant, 2'b01);
    chk("mid first_grant_fp", f_grant, 2'b01);
    chk("mid first_cmd", {u_type, u_addr, u_num}, {2'd2, 24'hAAAAAA, 9'd5});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
